// File: rtl/des_key_scheduler.sv
// DES round-key generator: loads a 64-bit key, then streams the sixteen 48-bit
// PC-2 subkeys through a valid/ready handshake, in forward or reverse order.
module des_key_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:64] key_in,
   input  logic        decrypt,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic        abort,
   output logic [1:48] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int unsigned PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   state_t      state_q, state_d;
   logic [1:28] c_q, c_d;
   logic [1:28] d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        mode_q, mode_d;

   logic [1:56] pc1_key;
   logic [1:56] cd_q;
   logic        rot_two;
   logic        unused_parity;

   // Parity bits play no part in the schedule.
   assign unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                            key_in[40], key_in[48], key_in[56], key_in[64]};

   assign cd_q = {c_q, d_q};

   genvar gi;
   generate
      for (gi = 0; gi < 56; gi++) begin : g_pc1
         assign pc1_key[gi+1] = key_in[PC1_TAB[gi]];
      end
      for (gi = 0; gi < 48; gi++) begin : g_pc2
         assign subkey[gi+1] = cd_q[PC2_TAB[gi]];
      end
   endgenerate

   function automatic logic [1:28] rot_l(input logic [1:28] x, input logic two);
      return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
   endfunction

   function automatic logic [1:28] rot_r(input logic [1:28] x, input logic two);
      return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
   endfunction

   // Emission indices 2, 9 and 16 shift by one bit in both directions.
   assign rot_two = !((round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14));

   always_comb begin
      state_d      = state_q;
      c_d          = c_q;
      d_d          = d_q;
      round_d      = round_q;
      mode_d       = mode_q;
      key_ready    = 1'b0;
      subkey_valid = 1'b0;
      done         = 1'b0;

      case (state_q)
         IDLE:    key_ready    = 1'b1;
         GEN:     subkey_valid = 1'b1;
         FIN:     done         = 1'b1;
         default: ;
      endcase

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  c_d     = decrypt ? pc1_key[1:28]  : rot_l(pc1_key[1:28], 1'b0);
                  d_d     = decrypt ? pc1_key[29:56] : rot_l(pc1_key[29:56], 1'b0);
                  mode_d  = decrypt;
                  round_d = 4'd0;
                  state_d = GEN;
               end
            end
            GEN: begin
               if (subkey_ready) begin
                  if (round_q == 4'd15) begin
                     state_d = FIN;
                  end else begin
                     round_d = round_q + 4'd1;
                     c_d     = mode_q ? rot_r(c_q, rot_two) : rot_l(c_q, rot_two);
                     d_d     = mode_q ? rot_r(d_q, rot_two) : rot_l(d_q, rot_two);
                  end
               end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= 4'd0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         mode_q  <= mode_d;
      end
   end

   assign round = round_q;

endmodule
